// File: rtl/pipe_control.sv
// Y86-64 pipeline control: hazard-derived stall/bubble/set_cc plus an IDLE/RUN/HALTED/TIMEOUT run-state FSM.
// Define PIPE_PERF_EN to add saturating performance counters on the perf_* ports.
module pipe_control #(
    parameter logic [31:0] WDOG_MAX = 32'd0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       W_icode,
    input  logic [3:0]       E_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic             e_Cnd,
    input  logic [1:0]       m_stat,
    input  logic [1:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic             busy,
    output logic             halted,
    output logic             timeout,
    output logic [1:0]       final_stat
`ifdef PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_cycles,
    output logic [CNT_W-1:0] perf_retired,
    output logic [CNT_W-1:0] perf_lu,
    output logic [CNT_W-1:0] perf_mispred,
    output logic [CNT_W-1:0] perf_ret
`endif
);

    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WDOG_MAX - 32'd1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALTED, ST_TIMEOUT} state_t;

    state_t           state_q;
    logic [1:0]       final_stat_q;
    logic [CNT_W-1:0] wd_cnt_q;
    logic             busy_q, halted_q, timeout_q;

    logic lu, mp, rt, mexc, wexc, wdog_hit;

    assign lu   = (E_icode == I_MRMOVQ || E_icode == I_POPQ) && (E_dstM != R_NONE)
                  && (E_dstM == d_srcA || E_dstM == d_srcB);
    assign mp   = (E_icode == I_JXX) && !e_Cnd;
    assign rt   = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign mexc = (m_stat != 2'b00);
    assign wexc = (W_stat != 2'b00);
    assign wdog_hit = (WDOG_MAX != 32'd0) && (wd_cnt_q == WD_LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            final_stat_q <= 2'b00;
            wd_cnt_q     <= '0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    wd_cnt_q <= '0;
                    if (start) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    wd_cnt_q <= wd_cnt_q + CNT_ONE;
                    // A write-back exception outranks a coincident watchdog expiry.
                    if (wexc) begin
                        state_q      <= ST_HALTED;
                        final_stat_q <= W_stat;
                        busy_q       <= 1'b0;
                        halted_q     <= 1'b1;
                    end else if (wdog_hit) begin
                        state_q   <= ST_TIMEOUT;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = busy_q;
    assign halted     = halted_q;
    assign timeout    = timeout_q;
    assign final_stat = final_stat_q;

    // NOTE: every output gets a default before the case so no latch can be inferred.
    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        set_cc   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                F_stall  = 1'b1;
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
            end
            ST_RUN: begin
                F_stall  = lu | rt;
                D_stall  = lu;
                D_bubble = mp | (rt & ~lu);
                E_bubble = mp | lu;
                M_bubble = mexc | wexc;
                W_stall  = wexc;
                set_cc   = (E_icode == I_OPQ) & ~mexc & ~wexc;
            end
            default: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                W_stall  = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
            end
        endcase
    end

`ifdef PIPE_PERF_EN
    localparam logic [3:0] I_NOP = 4'h1;

    // Index order: cycles, retired, load-use, mispredict, ret bubble.
    logic [4:0][CNT_W-1:0] perf_q, perf_d;
    logic [4:0]            perf_inc;

    assign perf_inc = {rt & ~lu, mp, lu, (W_icode != I_NOP) && (W_stat == 2'b00), 1'b1};

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            perf_d[i] = perf_q[i];
            if (state_q == ST_RUN && perf_inc[i] && perf_q[i] != '1)
                perf_d[i] = perf_q[i] + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) perf_q <= '0;
        else     perf_q <= perf_d;
    end

    assign perf_cycles  = perf_q[0];
    assign perf_retired = perf_q[1];
    assign perf_lu      = perf_q[2];
    assign perf_mispred = perf_q[3];
    assign perf_ret     = perf_q[4];
`else
    logic w_icode_unused;
    assign w_icode_unused = ^W_icode;
`endif

endmodule

// File: tb/tb_pipe_control.sv
// Self-checking bench for pipe_control: two instances (watchdog off / WDOG_MAX=8) against a behavioural model.
// Build with +define+PIPE_PERF_EN to also check the performance counters.
module tb_pipe_control;

    localparam logic [31:0] WD_A = 32'd0;
    localparam logic [31:0] WD_B = 32'd8;
    localparam int unsigned CW_A = 4;
    localparam int unsigned CW_B = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] D_icode, E_icode, M_icode, W_icode, E_dstM, d_srcA, d_srcB;
    logic       e_Cnd;
    logic [1:0] m_stat, W_stat;

    logic [6:0] ctrl [2];
    logic [2:0] sts [2];
    logic [1:0] fst [2];
    logic [CW_A-1:0] pa [5];
    logic [CW_B-1:0] pb [5];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_control #(.WDOG_MAX(WD_A), .CNT_W(CW_A)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .W_icode(W_icode),
        .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd),
        .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(ctrl[0][6]), .D_stall(ctrl[0][5]), .D_bubble(ctrl[0][4]), .E_bubble(ctrl[0][3]),
        .M_bubble(ctrl[0][2]), .W_stall(ctrl[0][1]), .set_cc(ctrl[0][0]),
        .busy(sts[0][2]), .halted(sts[0][1]), .timeout(sts[0][0]), .final_stat(fst[0])
`ifdef PIPE_PERF_EN
        , .perf_cycles(pa[0]), .perf_retired(pa[1]), .perf_lu(pa[2]), .perf_mispred(pa[3]), .perf_ret(pa[4])
`endif
    );

    pipe_control #(.WDOG_MAX(WD_B), .CNT_W(CW_B)) u_wd (
        .clk(clk), .rst(rst), .start(start),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .W_icode(W_icode),
        .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd),
        .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(ctrl[1][6]), .D_stall(ctrl[1][5]), .D_bubble(ctrl[1][4]), .E_bubble(ctrl[1][3]),
        .M_bubble(ctrl[1][2]), .W_stall(ctrl[1][1]), .set_cc(ctrl[1][0]),
        .busy(sts[1][2]), .halted(sts[1][1]), .timeout(sts[1][0]), .final_stat(fst[1])
`ifdef PIPE_PERF_EN
        , .perf_cycles(pb[0]), .perf_retired(pb[1]), .perf_lu(pb[2]), .perf_mispred(pb[3]), .perf_ret(pb[4])
`endif
    );

`ifndef PIPE_PERF_EN
    initial begin
        for (int j = 0; j < 5; j++) begin
            pa[j] = '0;
            pb[j] = '0;
        end
    end
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 running, 2 halted, 3 timed out
    int              mode [2];
    longint unsigned run_cycles [2];
    logic [1:0]      m_fstat [2];
    longint unsigned m_perf [2][5];
    longint unsigned wd_lim [2] = '{64'(WD_A), 64'(WD_B)};
    longint unsigned p_max  [2] = '{64'd15, 64'hFFFF_FFFF};
    bit              model_ok = 1'b0;

    // {load_use, mispredict, ret_in_flight, mem_exc, wb_exc}
    function automatic logic [4:0] hazards();
        logic lu, mp, rt, me, we;
        lu = (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF
             && (E_dstM == d_srcA || E_dstM == d_srcB);
        mp = (E_icode == 4'h7) && !e_Cnd;
        rt = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
        me = (m_stat != 2'b00);
        we = (W_stat != 2'b00);
        return {lu, mp, rt, me, we};
    endfunction

    // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
    function automatic logic [6:0] exp_ctrl(input int md);
        logic [4:0] h;
        h = hazards();
        if (md == 0) return 7'b1011100;
        if (md != 1) return 7'b1101110;
        return {h[4] | h[2], h[4], h[3] | (h[2] & !h[4]), h[3] | h[4],
                h[1] | h[0], h[0], (E_icode == 4'h6) && !h[1] && !h[0]};
    endfunction

    always @(posedge clk) begin
        logic [4:0] h;
        logic [4:0] inc;
        h = hazards();
        inc = {h[2] & !h[4], h[3], h[4], (W_icode != 4'h1) && (W_stat == 2'b00), 1'b1};
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mode[k] = 0;
                run_cycles[k] = 0;
                m_fstat[k] = 2'b00;
                for (int j = 0; j < 5; j++) m_perf[k][j] = 0;
            end else if (mode[k] == 0) begin
                run_cycles[k] = 0;
                if (start) mode[k] = 1;
            end else if (mode[k] == 1) begin
                for (int j = 0; j < 5; j++)
                    if (inc[j] && m_perf[k][j] < p_max[k]) m_perf[k][j]++;
                run_cycles[k]++;
                if (h[0]) begin
                    mode[k] = 2;
                    m_fstat[k] = W_stat;
                end else if (wd_lim[k] != 0 && run_cycles[k] == wd_lim[k]) begin
                    mode[k] = 3;
                end
            end
        end
        if (rst) model_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("ctrl[%0d]", k), 64'(ctrl[k]), 64'(exp_ctrl(mode[k])));
                check($sformatf("status[%0d]", k), 64'(sts[k]),
                      64'({mode[k] == 1, mode[k] == 2, mode[k] == 3}));
                check($sformatf("final_stat[%0d]", k), 64'(fst[k]), 64'(m_fstat[k]));
`ifdef PIPE_PERF_EN
                for (int j = 0; j < 5; j++)
                    check($sformatf("perf[%0d][%0d]", k, j),
                          (k == 0) ? 64'(pa[j]) : 64'(pb[j]), m_perf[k][j]);
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neutral();
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
        E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
        e_Cnd = 1'b0; m_stat = 2'b00; W_stat = 2'b00;
    endtask

    task automatic lit_ctrl(input string name, input logic [6:0] exp);
        @(negedge clk);
        check(name, 64'(ctrl[0]), 64'(exp));
        cyc();
    endtask

    function automatic logic [3:0] rand_reg();
        if ($urandom_range(0, 3) == 0) return 4'hF;
        return 4'($urandom_range(0, 7));
    endfunction

    task automatic rand_inputs();
        logic [3:0] pool [8];
        pool = '{4'h5, 4'hB, 4'h7, 4'h6, 4'h9, 4'h1, 4'h2, 4'h0};
        rst     = ($urandom_range(0, 99) == 0);
        start   = ($urandom_range(0, 5) == 0);
        D_icode = pool[$urandom_range(0, 7)];
        E_icode = pool[$urandom_range(0, 7)];
        M_icode = pool[$urandom_range(0, 7)];
        W_icode = pool[$urandom_range(0, 7)];
        E_dstM  = rand_reg();
        d_srcA  = rand_reg();
        d_srcB  = rand_reg();
        e_Cnd   = 1'($urandom_range(0, 1));
        m_stat  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        W_stat  = ($urandom_range(0, 29) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    endtask

    initial begin
        neutral();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;

        // Idle after reset: bubbles in, PC held.
        repeat (5) cyc();
        @(negedge clk);
        check("idle ctrl", 64'(ctrl[0]), 64'(7'b1011100));
        check("idle status", 64'(sts[0]), 64'(3'b000));
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        @(negedge clk);
        check("run status", 64'(sts[0]), 64'(3'b100));
        check("run no hazard", 64'(ctrl[0]), 64'(7'b0000000));
        cyc();

        // Load/use.
        E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
        lit_ctrl("load-use", 7'b1101000);
        E_dstM = 4'hF; d_srcA = 4'hF;
        lit_ctrl("load-use rnone", 7'b0000000);

        // Mispredict.
        neutral(); E_icode = 4'h7; e_Cnd = 1'b0;
        lit_ctrl("mispredict", 7'b0011000);
        e_Cnd = 1'b1;
        lit_ctrl("jump taken", 7'b0000000);

        // Ret, then ret combined with load/use.
        neutral(); D_icode = 4'h9;
        lit_ctrl("ret", 7'b1010000);
        E_icode = 4'hB; E_dstM = 4'h4; d_srcA = 4'h4;
        lit_ctrl("ret+load-use", 7'b1101000);

        // set_cc and exceptions, then halt.
        neutral(); E_icode = 4'h6;
        lit_ctrl("set_cc", 7'b0000001);
        m_stat = 2'b10;
        lit_ctrl("mem exc", 7'b0000100);
        W_stat = 2'b01;
        @(negedge clk);
        check("wb exc", 64'(ctrl[0]), 64'(7'b0000110));
        cyc();
        neutral();
        @(negedge clk);
        check("halted status", 64'(sts[0]), 64'(3'b010));
        check("final_stat", 64'(fst[0]), 64'(2'b01));
        check("halted freeze", 64'(ctrl[0]), 64'(7'b1101110));
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        @(negedge clk);
        check("start ignored", 64'(sts[0]), 64'(3'b010));
        cyc();

        // Watchdog: exactly 8 RUN cycles on the WDOG_MAX=8 instance.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("wdog run %0d", i), 64'(sts[1]), 64'(3'b100));
            cyc();
        end
        @(negedge clk);
        check("wdog timeout", 64'(sts[1]), 64'(3'b001));
`ifdef PIPE_PERF_EN
        check("wdog perf_cycles", 64'(pb[0]), 64'd8);
`endif
        cyc();
        repeat (3) cyc();
`ifdef PIPE_PERF_EN
        @(negedge clk);
        check("perf_cycles hold", 64'(pb[0]), 64'd8);
        cyc();
`endif
        repeat (10) cyc();
`ifdef PIPE_PERF_EN
        @(negedge clk);
        check("perf saturate", 64'(pa[0]), 64'hF);
        cyc();
`endif

        // Randomised traffic, checked every cycle by the model.
        for (int i = 0; i < 4000; i++) begin
            rand_inputs();
            cyc();
        end
        rst = 1'b0;
        start = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
